// File: rtl/nibble_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// nibble_mul_seq_pkg
// Shared types, widths and helpers for the nibble-serial 8x8 multiplier
// sequencer (nibble_mul_seq) and its shift-tag delay line.
// -----------------------------------------------------------------------------
package nibble_mul_seq_pkg;

    localparam int NIB_W   = 4;
    localparam int OP_W    = 8;
    localparam int RES_W   = 16;
    localparam int N_PAIRS = 4;
    localparam int TAG_W   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Shift tag: number of nibble positions (0, 1 or 2) a partial product
    // must be moved left before it is added into the accumulator.
    typedef logic [TAG_W-1:0] tag_t;

    // Pair k multiplies a_nib[k[0]] by b_nib[k[1]], so its weight is k[0]+k[1].
    function automatic tag_t pair_tag(input logic [1:0] k);
        return tag_t'(k[0]) + tag_t'(k[1]);
    endfunction

    function automatic logic [NIB_W-1:0] nib_of(input logic [OP_W-1:0] v,
                                                 input logic             hi);
        return hi ? v[7:4] : v[3:0];
    endfunction

    // Place an 8-bit partial product at its nibble weight inside 16 bits.
    function automatic logic [RES_W-1:0] align_pp(input logic [OP_W-1:0] pp,
                                                   input tag_t            tag);
        logic [RES_W-1:0] w;
        w = {8'h00, pp};
        case (tag)
            2'd1:    return w << 4;
            2'd2:    return w << 8;
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/nibble_mul_seq_tag_delay.sv
// -----------------------------------------------------------------------------
// nibble_tag_delay
// DEPTH-stage shift register carrying {valid, shift_tag} alongside the external
// multiplier so each returning partial product arrives with its weight.
// DEPTH = 0 is a pure pass-through.
//   clk, reset        : clock, async active-high reset (clears all stages)
//   vld_in, tag_in    : tag launched with the operands
//   vld_out, tag_out  : tag aligned with mul_product
// -----------------------------------------------------------------------------
module nibble_tag_delay
    import nibble_mul_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic vld_in,
    input  tag_t tag_in,
    output logic vld_out,
    output tag_t tag_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign vld_out = vld_in;
            assign tag_out = tag_in;
        end else begin : g_regs
            logic [DEPTH-1:0] vld_pipe;
            tag_t [DEPTH-1:0] tag_pipe;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_pipe <= '0;
                    tag_pipe <= '0;
                end else begin
                    vld_pipe[0] <= vld_in;
                    tag_pipe[0] <= tag_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        tag_pipe[i] <= tag_pipe[i-1];
                    end
                end
            end

            assign vld_out = vld_pipe[DEPTH-1];
            assign tag_out = tag_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/nibble_mul_seq.sv
// -----------------------------------------------------------------------------
// nibble_mul_seq
// Multi-cycle 8x8 unsigned multiplier built around an external 4x4 multiplier.
// Four nibble pairs are issued on consecutive cycles; returning partial
// products are shifted by their tag and accumulated into a 16-bit result.
//   clk, reset          : clock, async active-high reset
//   start, op_a, op_b   : request + operands (sampled only in IDLE)
//   busy                : operation in progress (accept edge .. done edge)
//   done                : one-cycle pulse, result valid
//   result              : op_a*op_b, held until the next done
//   mul_op1, mul_op2    : nibbles to the external multiplier
//   mul_product         : partial product, MUL_LATENCY cycles after operands
// -----------------------------------------------------------------------------
module nibble_mul_seq
    import nibble_mul_seq_pkg::*;
#(
    parameter int MUL_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic [NIB_W-1:0] mul_op1,
    output logic [NIB_W-1:0] mul_op2,
    input  logic [OP_W-1:0]  mul_product
);

    // Edges from accept to the final capture; also the RUN length in cycles.
    localparam int CNT_W     = 3;
    localparam int RUN_EDGES = N_PAIRS + MUL_LATENCY;

    state_t           state, state_nxt;
    logic             accept, finish;
    logic [CNT_W-1:0] cnt;          // index of the next RUN edge (E1, E2, ...)
    logic [OP_W-1:0]  a_q, b_q;
    logic [RES_W-1:0] acc, acc_nxt;
    logic             issue_vld, cap_vld;
    tag_t             issue_tag, cap_tag;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (cnt == CNT_W'(RUN_EDGES)) begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // ---------------- tag pipe ----------------
    // Tags are launched together with the registered operands, so after
    // MUL_LATENCY stages they line up with the matching mul_product.
    nibble_tag_delay #(.DEPTH(MUL_LATENCY)) u_tag_delay (
        .clk     (clk),
        .reset   (reset),
        .vld_in  (issue_vld),
        .tag_in  (issue_tag),
        .vld_out (cap_vld),
        .tag_out (cap_tag)
    );

    assign acc_nxt = cap_vld ? acc + align_pp(mul_product, cap_tag) : acc;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            done      <= 1'b0;
            mul_op1   <= '0;
            mul_op2   <= '0;
            issue_vld <= 1'b0;
            issue_tag <= '0;
        end else begin
            // Operands default to zero so the multiplier sees 0 outside issue.
            done      <= 1'b0;
            mul_op1   <= '0;
            mul_op2   <= '0;
            issue_vld <= 1'b0;
            issue_tag <= '0;
            if (accept) begin
                a_q       <= op_a;
                b_q       <= op_b;
                acc       <= '0;
                cnt       <= CNT_W'(1);
                // Pair 0 goes out on the accept edge itself.
                mul_op1   <= nib_of(op_a, 1'b0);
                mul_op2   <= nib_of(op_b, 1'b0);
                issue_vld <= 1'b1;
                issue_tag <= pair_tag(2'd0);
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
                acc <= acc_nxt;
                if (cnt < CNT_W'(N_PAIRS)) begin
                    mul_op1   <= nib_of(a_q, cnt[0]);
                    mul_op2   <= nib_of(b_q, cnt[1]);
                    issue_vld <= 1'b1;
                    issue_tag <= pair_tag(cnt[1:0]);
                end
                if (finish) begin
                    result <= acc_nxt;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_mul_seq.sv
// Bench: three sequencers (multiplier latency 0, 1, 2), each paired with a
// behavioural 4x4 multiplier of matching latency, checked against a*b and
// the nibble-pair issue rules.
module tb_nibble_mul_seq;

    logic        clk;
    logic        reset;
    logic [2:0]  start;
    logic [7:0]  op_a [3];
    logic [7:0]  op_b [3];
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [15:0] result [3];
    logic [3:0]  mul_op1 [3];
    logic [3:0]  mul_op2 [3];
    logic [7:0]  mul_product [3];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [7:0] p1, p2;
        always_ff @(posedge clk) begin
            p1 <= mul_op1[g] * mul_op2[g];
            p2 <= p1;
        end
        assign mul_product[g] = (g == 0) ? 8'(mul_op1[g] * mul_op2[g]) :
                                (g == 1) ? p1 : p2;

        nibble_mul_seq #(.MUL_LATENCY(g)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start[g]),
            .op_a        (op_a[g]),
            .op_b        (op_b[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .result      (result[g]),
            .mul_op1     (mul_op1[g]),
            .mul_op2     (mul_op2[g]),
            .mul_product (mul_product[g])
        );
    end

    // Reference: operand pair issued in slot k.
    function automatic logic [7:0] exp_pair(input logic [7:0] a, input logic [7:0] b, input int k);
        logic [3:0] x, y;
        x = 4'((a >> (4 * (k % 2))) & 8'h0F);
        y = 4'((b >> (4 * (k / 2))) & 8'h0F);
        return {x, y};
    endfunction

    // Drives one operation on DUT d and records what it observed (no checks).
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] res, output int lat, output logic [31:0] ops,
                          output int ops_bad, output int held_bad, output int extra);
        logic [15:0] old;
        old = result[d];
        res = 16'hxxxx; lat = -1; ops = '0; ops_bad = 0; held_bad = 0; extra = 0;
        @(negedge clk);
        op_a[d] = a; op_b[d] = b; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (int n = 0; n <= 20 && lat < 0; n++) begin
            if (n > 0) @(negedge clk);
            if (n < 4) ops[n*8 +: 8] = {mul_op1[d], mul_op2[d]};
            else if (mul_op1[d] != 4'd0 || mul_op2[d] != 4'd0) ops_bad++;
            if (done[d]) begin
                lat = n; res = result[d];
            end else if (result[d] !== old || busy[d] !== 1'b1) held_bad++;
        end
        @(negedge clk);
        if (done[d] !== 1'b0 || busy[d] !== 1'b0) extra++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = '0;
        for (int i = 0; i < 3; i++) begin op_a[i] = '0; op_b[i] = '0; end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0 || result[i] !== 16'h0000 ||
                mul_op1[i] !== 4'd0 || mul_op2[i] !== 4'd0) begin
                bad++;
                $display("FAIL reset_state dut%0d: busy=%b done=%b result=%h op1=%h op2=%h required 0",
                         i, busy[i], done[i], result[i], mul_op1[i], mul_op2[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] r; int lat, ob, hb, ex; logic [31:0] ops;
        run_op(1, 8'h12, 8'h34, r, lat, ops, ob, hb, ex);
        total++;
        if (ops !== 32'h1323_1424) begin
            bad++; $display("FAIL basic_ops: got %h required 13231424", ops);
        end
        total++;
        if (lat !== 5) begin bad++; $display("FAIL basic_latency: got %0d required 5", lat); end
        total++;
        if (r !== 16'h03A8) begin bad++; $display("FAIL basic_result: got %h required 03a8", r); end
        total++;
        if (ob != 0 || hb != 0 || ex != 0) begin
            bad++; $display("FAIL basic_idle_ops/held/pulse: got %0d/%0d/%0d required 0/0/0", ob, hb, ex);
        end
    endtask

    task automatic test_identity();
        logic [7:0] va [3] = '{8'h00, 8'hA5, 8'hFF};
        logic [7:0] vb [3] = '{8'hAB, 8'h01, 8'hFF};
        logic [15:0] ve [3] = '{16'h0000, 16'h00A5, 16'hFE01};
        logic [15:0] r; int lat, ob, hb, ex; logic [31:0] ops;
        for (int i = 0; i < 3; i++) begin
            run_op(1, va[i], vb[i], r, lat, ops, ob, hb, ex);
            total++;
            if (r !== ve[i] || lat !== 5) begin
                bad++;
                $display("FAIL identity %h*%h: got %h lat %0d required %h lat 5", va[i], vb[i], r, lat, ve[i]);
            end
        end
    endtask

    task automatic test_busy_protect();
        int dones = 0; int dlat = -1; logic [15:0] r = 16'h0;
        @(negedge clk);
        op_a[1] = 8'h12; op_b[1] = 8'h34; start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (n > 0) @(negedge clk);
            if (n >= 1 && n <= 3) begin start[1] = 1'b1; op_a[1] = 8'h99; end
            else start[1] = 1'b0;
            if (done[1]) begin dones++; dlat = n; r = result[1]; end
        end
        start[1] = 1'b0;
        total++;
        if (dones != 1 || dlat != 5 || r !== 16'h03A8) begin
            bad++;
            $display("FAIL busy_protect: dones=%0d at %0d result %h required 1 at 5 result 03a8", dones, dlat, r);
        end
    endtask

    task automatic test_back_to_back();
        int l1 = -1; int l2 = -1; int hb = 0; logic [15:0] r1 = '0; logic [15:0] r2 = '0;
        @(negedge clk);
        op_a[1] = 8'h12; op_b[1] = 8'h34; start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        for (int n = 0; n < 25 && l2 < 0; n++) begin
            if (n > 0) @(negedge clk);
            if (l1 < 0) begin
                if (done[1]) begin
                    l1 = n; r1 = result[1];
                    op_a[1] = 8'h0F; op_b[1] = 8'h10; start[1] = 1'b1;
                end
            end else if (n == l1 + 1) begin
                start[1] = 1'b0;
                if (busy[1] !== 1'b1 || done[1] !== 1'b0 || result[1] !== 16'h03A8) hb++;
            end else if (done[1]) begin
                l2 = n; r2 = result[1];
            end else if (result[1] !== 16'h03A8) hb++;
        end
        start[1] = 1'b0;
        total++;
        if (l1 !== 5 || r1 !== 16'h03A8) begin
            bad++; $display("FAIL b2b_first: lat %0d result %h required 5 03a8", l1, r1);
        end
        total++;
        if (l2 - l1 !== 6 || r2 !== 16'h00F0) begin
            bad++; $display("FAIL b2b_second: gap %0d result %h required 6 00f0", l2 - l1, r2);
        end
        total++;
        if (hb != 0) begin bad++; $display("FAIL b2b_held: %0d bad cycles required 0", hb); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        logic [15:0] r; int lat, ob, hb, ex; logic [31:0] ops;
        @(negedge clk);
        op_a[1] = 8'hFF; op_b[1] = 8'hFF; start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (done[1]) dones++;
            @(negedge clk);
        end
        total++;
        if (busy[1] !== 1'b0 || result[1] !== 16'h0000 || dones != 0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b result=%h dones=%0d required 0 0000 0", busy[1], result[1], dones);
        end
        run_op(1, 8'hFF, 8'hFF, r, lat, ops, ob, hb, ex);
        total++;
        if (r !== 16'hFE01 || lat !== 5) begin
            bad++; $display("FAIL reset_mid_rerun: got %h lat %0d required fe01 lat 5", r, lat);
        end
    endtask

    task automatic test_latency();
        logic [15:0] r; int lat, ob, hb, ex; logic [31:0] ops;
        for (int d = 0; d < 3; d += 2) begin
            run_op(d, 8'h12, 8'h34, r, lat, ops, ob, hb, ex);
            total++;
            if (lat !== 4 + d || r !== 16'h03A8 || ops !== 32'h1323_1424 || ob != 0 || hb != 0 || ex != 0) begin
                bad++;
                $display("FAIL latency%0d: lat %0d result %h ops %h flags %0d/%0d/%0d required %0d 03a8 13231424 0/0/0",
                         d, lat, r, ops, ob, hb, ex, 4 + d);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] r; int lat, ob, hb, ex; logic [31:0] ops, eops;
        logic [7:0] a, b; int d;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); d = i % 3;
            run_op(d, a, b, r, lat, ops, ob, hb, ex);
            for (int k = 0; k < 4; k++) eops[k*8 +: 8] = exp_pair(a, b, k);
            total++;
            if (r !== 16'(a) * 16'(b)) begin
                bad++; $display("FAIL random_result dut%0d %h*%h: got %h required %h", d, a, b, r, 16'(a) * 16'(b));
            end
            total++;
            if (lat !== 4 + d || ops !== eops || ob != 0 || hb != 0 || ex != 0) begin
                bad++;
                $display("FAIL random_timing dut%0d %h*%h: lat %0d ops %h flags %0d/%0d/%0d required %0d %h 0/0/0",
                         d, a, b, lat, ops, ob, hb, ex, 4 + d, eops);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_identity();
        test_busy_protect();
        test_back_to_back();
        test_reset_mid();
        test_latency();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
